// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and defaults for the I2S receiver.
//   i2s_rx_state_t  receiver alignment FSM states
//   I2S_DW_DEFAULT  default PCM word width per channel
package i2s_pkg;

  typedef enum logic [1:0] {HUNT, WAIT_L, RX_L, RX_R} i2s_rx_state_t;

  localparam int I2S_DW_DEFAULT = 16;

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: brings the asynchronous I2S pins into the clk domain.
// Each pin passes through a 2-FF synchronizer; a registered rise detector on
// the synchronized bit clock produces a one-cycle sclk_rise strobe, and the
// word-select and data bits are registered alongside it so all three line up.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   sclk, lrclk, sdata asynchronous I2S pins
//   sclk_rise         1-clk strobe per detected bit-clock rise
//   lr_s, sd_s        word select / data sampled for that rise
module i2s_rx_sync
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic lrclk,
  input  logic sdata,
  output logic sclk_rise,
  output logic lr_s,
  output logic sd_s
);

  // bit order in the synchronizer vectors: {sdata, lrclk, sclk}
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       rise_q, rise_d;
  logic       lr_q, lr_d;
  logic       sd_q, sd_d;

  always_comb begin
    meta_d      = {sdata, lrclk, sclk};
    sync_d      = meta_q;
    sclk_prev_d = sync_q[0];
    rise_d      = sync_q[0] & ~sclk_prev_q;
    lr_d        = sync_q[1];
    sd_d        = sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      lr_q        <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      rise_q      <= rise_d;
      lr_q        <= lr_d;
      sd_q        <= sd_d;
    end
  end

  assign sclk_rise = rise_q;
  assign lr_s      = lr_q;
  assign sd_s      = sd_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Oversamples sclk/lrclk/sdata on clk, aligns to the
// word-select boundaries and delivers one left/right PCM pair per frame.
// Optional feature macro: I2S_RX_LOCK_DET_EN adds an sclk watchdog and a
// half-frame length check, both of which drop the receiver back to HUNT.
// Ports:
//   clk, reset               system clock (>= 4x sclk), synchronous active-high reset
//   sclk, lrclk, sdata       asynchronous I2S inputs (lrclk: 0=left, 1=right)
//   left_chan, right_chan    last complete stereo pair
//   sample_valid             1-clk pulse when the pair updates
//   frame_err                sticky short-word flag, cleared by reset only
//   locked                   receiver aligned to lrclk
//
// state  | meaning
// HUNT   | unaligned, waiting for any lr boundary
// WAIT_L | saw 0->1, waiting for the 1->0 that starts a left word
// RX_L   | receiving left word
// RX_R   | receiving right word; 1->0 boundary publishes the pair
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = I2S_DW_DEFAULT,
  parameter int CNT_W    = 6,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                frame_err,
  output logic                locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic sclk_rise, lr_s, sd_s;

  i2s_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .sclk_rise(sclk_rise),
    .lr_s     (lr_s),
    .sd_s     (sd_s)
  );

  i2s_rx_state_t       state_q, state_d;
  logic                lr_prev_q, lr_prev_d;
  logic [AUDIO_DW-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [AUDIO_DW-1:0] left_hold_q, left_hold_d;
  logic [AUDIO_DW-1:0] left_chan_q, left_chan_d;
  logic [AUDIO_DW-1:0] right_chan_q, right_chan_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                boundary;
  logic                short_word;
  logic [CNT_W-1:0]    n_bits;
  logic [AUDIO_DW-1:0] shifted;
  logic [AUDIO_DW-1:0] word;

`ifdef I2S_RX_LOCK_DET_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);

  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0] prev_len_q, prev_len_d;
  logic             len_valid_q, len_valid_d;
`else
  // TIMEOUT only matters when lock detection is built in
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    sreg_d       = sreg_q;
    bitcnt_d     = bitcnt_q;
    left_hold_d  = left_hold_q;
    left_chan_d  = left_chan_q;
    right_chan_d = right_chan_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    boundary     = 1'b0;

    // Bit count of the half-frame if the current edge is counted (saturating).
    n_bits     = (bitcnt_q == CNT_MAX) ? CNT_MAX : bitcnt_q + CNT_W'(1);
    shifted    = (int'(bitcnt_q) < AUDIO_DW) ? {sreg_q[AUDIO_DW-2:0], sd_s} : sreg_q;
    short_word = int'(n_bits) < AUDIO_DW;
    // Short words are left-aligned so the received bits keep their weight.
    word       = short_word ? (shifted << (AUDIO_DW - int'(n_bits))) : shifted;

    if (sclk_rise) begin
      boundary  = (lr_s != lr_prev_q);
      lr_prev_d = lr_s;
      if (boundary) begin
        // The boundary edge carries the LSB of the finishing word.
        sreg_d   = '0;
        bitcnt_d = '0;
        case (state_q)
          HUNT:    state_d = lr_s ? WAIT_L : RX_L;
          WAIT_L:  if (!lr_s) state_d = RX_L;
          RX_L: begin
            left_hold_d = word;
            if (short_word) err_d = 1'b1;
            state_d = RX_R;
          end
          RX_R: begin
            left_chan_d  = left_hold_q;
            right_chan_d = word;
            valid_d      = 1'b1;
            if (short_word) err_d = 1'b1;
            state_d = RX_L;
          end
          default: state_d = HUNT;
        endcase
      end else begin
        sreg_d   = shifted;
        bitcnt_d = n_bits;
      end
    end

`ifdef I2S_RX_LOCK_DET_EN
    wdog_d      = sclk_rise ? '0 : ((wdog_q == TIMEOUT_V) ? wdog_q : wdog_q + WD_W'(1));
    prev_len_d  = prev_len_q;
    len_valid_d = len_valid_q;
    if (boundary) begin
      prev_len_d  = n_bits;
      // Only half-frames received while aligned are a trustworthy reference.
      len_valid_d = (state_q == RX_L) || (state_q == RX_R);
      if (len_valid_q && ((state_q == RX_L) || (state_q == RX_R)) && (n_bits != prev_len_q)) begin
        state_d      = HUNT;
        sreg_d       = '0;
        left_hold_d  = left_hold_q;
        left_chan_d  = left_chan_q;
        right_chan_d = right_chan_q;
        valid_d      = 1'b0;
        len_valid_d  = 1'b0;
      end
    end
    if (wdog_q == TIMEOUT_V) begin
      state_d      = HUNT;
      sreg_d       = '0;
      bitcnt_d     = '0;
      left_hold_d  = left_hold_q;
      left_chan_d  = left_chan_q;
      right_chan_d = right_chan_q;
      valid_d      = 1'b0;
      len_valid_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      lr_prev_q    <= 1'b0;
      sreg_q       <= '0;
      bitcnt_q     <= '0;
      left_hold_q  <= '0;
      left_chan_q  <= '0;
      right_chan_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef I2S_RX_LOCK_DET_EN
      wdog_q       <= '0;
      prev_len_q   <= '0;
      len_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lr_prev_q    <= lr_prev_d;
      sreg_q       <= sreg_d;
      bitcnt_q     <= bitcnt_d;
      left_hold_q  <= left_hold_d;
      left_chan_q  <= left_chan_d;
      right_chan_q <= right_chan_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
`ifdef I2S_RX_LOCK_DET_EN
      wdog_q       <= wdog_d;
      prev_len_q   <= prev_len_d;
      len_valid_q  <= len_valid_d;
`endif
    end
  end

  assign left_chan    = left_chan_q;
  assign right_chan   = right_chan_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = (state_q == RX_L) || (state_q == RX_R);

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic [15:0] left_chan;
  logic [15:0] right_chan;
  logic        sample_valid;
  logic        frame_err;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;

  int          clk_ctr  = 0;
  int          rise_clk = 0;
  int          vcount   = 0;
  int          last_lat = 0;
  logic [15:0] last_l   = '0;
  logic [15:0] last_r   = '0;
  logic        lr_sent  = 1'b0;

  i2s_rx dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .left_chan   (left_chan),
    .right_chan  (right_chan),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  // 48 MHz system clock
  always #10.417 clk = ~clk;

  always @(posedge clk) clk_ctr <= clk_ctr + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      vcount   <= vcount + 1;
      last_l   <= left_chan;
      last_r   <= right_chan;
      last_lat <= clk_ctr - rise_clk;
    end
  end

  // Half sclk period of 7-8 clk plus a random sub-clk offset: about 3 MHz with
  // random phase and up to one clk of jitter; edges never land on a clk edge.
  task automatic half_wait();
    repeat (7 + $urandom_range(0, 1)) @(posedge clk);
    #($urandom_range(3, 17));
  endtask

  // One bit clock: lr/sd change on the fall, receiver samples on the rise.
  task automatic sclk_cycle(input logic lr, input logic sd);
    half_wait();
    sclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    half_wait();
    if (lr_sent && !lr) rise_clk = clk_ctr;
    sclk    = 1'b1;
    lr_sent = lr;
  endtask

  // A slot of 'slot' bit clocks for channel ch, word MSB first, zero padded.
  // The last cycle already carries the next channel's lr (standard I2S).
  task automatic send_slot(input logic ch, input logic [15:0] w, input int nbits,
                           input int slot, input int first);
    for (int i = first; i < slot; i++)
      sclk_cycle((i == slot - 1) ? ~ch : ch, (i < nbits) ? w[nbits-1-i] : 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int nbits, input int slot);
    send_slot(1'b0, l, nbits, slot, 0);
    send_slot(1'b1, r, nbits, slot, 0);
  endtask

  // Tail of a dummy right word so the first real left word is aligned.
  task automatic lead_in();
    sclk_cycle(1'b1, 1'b0);
    sclk_cycle(1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    sclk    = 1'b0;
    lrclk   = 1'b0;
    sdata   = 1'b0;
    lr_sent = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (left_chan !== 16'h0000) begin n_fail++; $display("FAIL reset_left: got %h exp 0000", left_chan); end
    n_checks++; if (right_chan !== 16'h0000) begin n_fail++; $display("FAIL reset_right: got %h exp 0000", right_chan); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", sample_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", frame_err); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b exp 0", locked); end
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = vcount;
    lead_in();
    send_frame(16'h8001, 16'h7FFE, 16, 32);
    settle();
    n_checks++; if (vcount - base !== 1) begin n_fail++; $display("FAIL basic_count: got %0d exp 1", vcount - base); end
    n_checks++; if (last_l !== 16'h8001) begin n_fail++; $display("FAIL basic_left: got %h exp 8001", last_l); end
    n_checks++; if (last_r !== 16'h7FFE) begin n_fail++; $display("FAIL basic_right: got %h exp 7ffe", last_r); end
    n_checks++; if (left_chan !== 16'h8001) begin n_fail++; $display("FAIL basic_left_hold: got %h exp 8001", left_chan); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b exp 0", frame_err); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked: got %b exp 1", locked); end
  endtask

  task automatic test_mid_right();
    int base;
    do_reset();
    base = vcount;
    for (int i = 0; i < 7; i++) sclk_cycle(1'b1, 1'($urandom_range(0, 1)));
    sclk_cycle(1'b0, 1'b1);
    send_slot(1'b0, 16'hC3A5, 16, 32, 0);
    settle();
    n_checks++; if (vcount - base !== 0) begin n_fail++; $display("FAIL mid_no_partial: got %0d exp 0", vcount - base); end
    send_slot(1'b1, 16'h0F0F, 16, 32, 0);
    settle();
    n_checks++; if (vcount - base !== 1) begin n_fail++; $display("FAIL mid_count: got %0d exp 1", vcount - base); end
    n_checks++; if (last_l !== 16'hC3A5) begin n_fail++; $display("FAIL mid_left: got %h exp c3a5", last_l); end
    n_checks++; if (last_r !== 16'h0F0F) begin n_fail++; $display("FAIL mid_right: got %h exp 0f0f", last_r); end
  endtask

  task automatic test_short_word();
    do_reset();
    lead_in();
    send_frame(16'h0ABC, 16'h0123, 12, 12);
    settle();
    n_checks++; if (last_l !== 16'hABC0) begin n_fail++; $display("FAIL short_left: got %h exp abc0", last_l); end
    n_checks++; if (last_r !== 16'h1230) begin n_fail++; $display("FAIL short_right: got %h exp 1230", last_r); end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b exp 1", frame_err); end
    send_frame(16'h1111, 16'h2222, 16, 32);
    send_frame(16'h3333, 16'h4444, 16, 32);
    send_frame(16'h5555, 16'h6666, 16, 32);
    settle();
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky: got %b exp 1", frame_err); end
    n_checks++; if (last_l !== 16'h5555) begin n_fail++; $display("FAIL short_good_left: got %h exp 5555", last_l); end
    n_checks++; if (last_r !== 16'h6666) begin n_fail++; $display("FAIL short_good_right: got %h exp 6666", last_r); end
  endtask

  task automatic test_latency_random();
    int          base;
    logic [15:0] l, r;
    do_reset();
    lead_in();
    base = vcount;
    for (int k = 0; k < 3; k++) begin
      send_frame(16'h1234, 16'h5678, 16, 32);
      settle();
      n_checks++; if (last_lat !== 4) begin n_fail++; $display("FAIL latency_%0d: got %0d exp 4", k, last_lat); end
      n_checks++; if (vcount - base !== k + 1) begin n_fail++; $display("FAIL latency_count_%0d: got %0d exp %0d", k, vcount - base, k + 1); end
      n_checks++; if ({last_l, last_r} !== 32'h12345678) begin n_fail++; $display("FAIL latency_data_%0d: got %h exp 12345678", k, {last_l, last_r}); end
    end
    for (int k = 0; k < 20; k++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      send_frame(l, r, 16, 32);
      settle();
      n_checks++; if ({last_l, last_r} !== {l, r}) begin n_fail++; $display("FAIL random_data_%0d: got %h exp %h", k, {last_l, last_r}, {l, r}); end
      n_checks++; if (last_lat !== 4) begin n_fail++; $display("FAIL random_latency_%0d: got %0d exp 4", k, last_lat); end
    end
    n_checks++; if (vcount - base !== 23) begin n_fail++; $display("FAIL random_count: got %0d exp 23", vcount - base); end
  endtask

  task automatic test_reset_mid_word();
    int base;
    send_slot(1'b0, 16'hFFFF, 16, 32, 0);
    send_slot(1'b1, 16'hFFFF, 16, 32, 0);
    send_slot(1'b0, 16'hBEEF, 16, 32, 0);
    for (int i = 0; i < 10; i++) sclk_cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) sclk_cycle(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (left_chan !== 16'h0000) begin n_fail++; $display("FAIL rstmid_left: got %h exp 0000", left_chan); end
    n_checks++; if (right_chan !== 16'h0000) begin n_fail++; $display("FAIL rstmid_right: got %h exp 0000", right_chan); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b exp 0", sample_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rstmid_locked: got %b exp 0", locked); end
    base = vcount;
    send_slot(1'b0, 16'h1357, 16, 32, 10);
    send_slot(1'b1, 16'h2468, 16, 32, 0);
    settle();
    n_checks++; if (vcount - base !== 0) begin n_fail++; $display("FAIL rstmid_no_partial: got %0d exp 0", vcount - base); end
    send_frame(16'hA5A5, 16'h5A5A, 16, 32);
    settle();
    n_checks++; if (vcount - base !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d exp 1", vcount - base); end
    n_checks++; if ({last_l, last_r} !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rstmid_data: got %h exp a5a55a5a", {last_l, last_r}); end
  endtask

  task automatic test_sclk_stop();
    repeat (990) @(negedge clk);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stop_locked_early: got %b exp 1", locked); end
    repeat (110) @(negedge clk);
`ifdef I2S_RX_LOCK_DET_EN
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stop_locked_late: got %b exp 0", locked); end
`else
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stop_locked_late: got %b exp 1", locked); end
`endif
    n_checks++; if ({left_chan, right_chan} !== 32'hA5A55A5A) begin n_fail++; $display("FAIL stop_hold: got %h exp a5a55a5a", {left_chan, right_chan}); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL stop_err: got %b exp 0", frame_err); end
    send_frame(16'h1357, 16'h2468, 16, 32);
    settle();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL restart_locked: got %b exp 1", locked); end
    send_frame(16'h9ABC, 16'hDEF0, 16, 32);
    settle();
    n_checks++; if ({last_l, last_r} !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL restart_data: got %h exp 9abcdef0", {last_l, last_r}); end
  endtask

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    test_reset();
    test_basic();
    test_mid_right();
    test_short_word();
    test_latency_random();
    test_reset_mid_word();
    test_sclk_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
